// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release sequencer
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 10000,
    parameter int LOCK_STABLE    = 1024,
    parameter int RETRY_LIMIT    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    retry_n, retry_inc;
    logic          lock_lost_n;
    logic          sync1, locked_s;

    // pll_locked is asynchronous to refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    assign retry_inc = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CW'(1);
        retry_n     = retry_cnt;
        lock_lost_n = 1'b0;
        case (state)
            S_PLLRST: begin
                if (cnt == PLL_RST_LAST) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // a lock seen on the timeout edge wins over the retry
                if (locked_s) begin
                    state_n = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (RETRY_LIMIT != 0 && int'({28'd0, retry_cnt}) >= RETRY_LIMIT) begin
                        state_n = S_FAIL;
                    end else begin
                        retry_n = retry_inc;
                        state_n = S_PLLRST;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s)                state_n = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_n = S_RUN;
            end
            S_RUN: begin
                cnt_n = '0;
                if (!locked_s) begin
                    lock_lost_n = 1'b1;
                    retry_n     = retry_inc;
                    state_n     = S_PLLRST;
                end
            end
            S_FAIL: begin
                cnt_n = '0;
            end
            default: begin
                state_n = S_FAIL;
            end
        endcase
        if (state_n != state) cnt_n = '0;
    end

    // outputs are decoded from the next state so they change on the transition edge
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
            retry_cnt <= 4'd0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pll_rst   <= (state_n == S_PLLRST) || (state_n == S_FAIL);
            sys_rst   <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            lock_lost <= lock_lost_n;
            retry_cnt <= retry_n;
            fail      <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst, ready, lock_lost, fail;
    logic [3:0] retry_cnt;

    int passed = 0;
    int total  = 0;
    int lost_pulses = 0;
    int lost_back_to_back = 0;
    int invariant_bad = 0;
    logic lost_prev = 1'b0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .RETRY_LIMIT   (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .fail      (fail)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk) begin
        #1;
        if (lock_lost === 1'b1) lost_pulses++;
        if (lock_lost === 1'b1 && lost_prev === 1'b1) lost_back_to_back++;
        lost_prev = lock_lost;
        if (ready === 1'b1 && (sys_rst !== 1'b0 || pll_rst !== 1'b0)) invariant_bad++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic tick_until_ready(input int limit, output int n, output bit saw_pll_rst);
        n = 0;
        saw_pll_rst = 1'b0;
        while (1) begin
            tick(1);
            n++;
            if (pll_rst === 1'b1) saw_pll_rst = 1'b1;
            if (ready === 1'b1) break;
            if (n >= limit) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic count_until_pll(input logic val, input int limit, output int n);
        n = 0;
        while (1) begin
            tick(1);
            n++;
            if (pll_rst === val) break;
            if (n >= limit) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic restart(input logic locked_at_release);
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(2);
        pll_locked = locked_at_release;
        rst = 1'b0;
        lost_pulses = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        total++;
        if ({pll_rst, sys_rst, ready, lock_lost, retry_cnt, fail} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            $display("FAIL reset_values: got pll_rst=%b sys_rst=%b ready=%b lock_lost=%b retry=%0d fail=%b want 1 1 0 0 0 0",
                     pll_rst, sys_rst, ready, lock_lost, retry_cnt, fail);
        end else passed++;
    endtask

    task automatic test_bringup;
        int n;
        bit saw;
        logic [2:0] hi;
        restart(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            hi[i] = pll_rst;
        end
        tick(1);
        total++;
        if ({hi, pll_rst} !== 4'b1110) $display("FAIL bringup_pll_rst_width: got %b want 1110", {hi, pll_rst});
        else passed++;
        tick(6);
        pll_locked = 1'b1;
        tick_until_ready(40, n, saw);
        total++;
        if (n !== 11) $display("FAIL bringup_ready_edge: got %0d want 11", n);
        else passed++;
        total++;
        if ({sys_rst, pll_rst, retry_cnt, saw} !== {1'b0, 1'b0, 4'd0, 1'b0})
            $display("FAIL bringup_outputs: got sys_rst=%b pll_rst=%b retry=%0d pll_rst_seen=%b want 0 0 0 0", sys_rst, pll_rst, retry_cnt, saw);
        else passed++;
        total++;
        if (lost_pulses !== 0) $display("FAIL bringup_lock_lost: got %0d pulses want 0", lost_pulses);
        else passed++;
    endtask

    task automatic test_lock_loss_run;
        int n;
        bit saw;
        lost_pulses = 0;
        pll_locked = 1'b0;
        tick(2);
        total++;
        if ({lock_lost, ready} !== 2'b01) $display("FAIL run_drop_early: got lock_lost=%b ready=%b want 0 1", lock_lost, ready);
        else passed++;
        tick(1);
        total++;
        if ({lock_lost, sys_rst, ready, pll_rst, retry_cnt} !== {1'b1, 1'b1, 1'b0, 1'b1, 4'd1})
            $display("FAIL run_drop_edge: got lock_lost=%b sys_rst=%b ready=%b pll_rst=%b retry=%0d want 1 1 0 1 1",
                     lock_lost, sys_rst, ready, pll_rst, retry_cnt);
        else passed++;
        tick(1);
        total++;
        if (lock_lost !== 1'b0) $display("FAIL run_lock_lost_width: got %b want 0", lock_lost);
        else passed++;
        tick(2);
        pll_locked = 1'b1;
        tick_until_ready(40, n, saw);
        total++;
        if (n !== 11 || retry_cnt !== 4'd1 || lost_pulses !== 1)
            $display("FAIL run_relock: got ticks=%0d retry=%0d pulses=%0d want 11 1 1", n, retry_cnt, lost_pulses);
        else passed++;
    endtask

    task automatic test_glitch_stable;
        int n;
        bit saw;
        restart(1'b0);
        tick(4);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick_until_ready(40, n, saw);
        total++;
        if (n !== 11) $display("FAIL glitch_ready_edge: got %0d want 11", n);
        else passed++;
        total++;
        if (retry_cnt !== 4'd0 || saw !== 1'b0)
            $display("FAIL glitch_no_retry: got retry=%0d pll_rst_seen=%b want 0 0", retry_cnt, saw);
        else passed++;
    endtask

    task automatic test_no_lock;
        int n;
        int widths[5];
        logic [3:0] r1, r2;
        restart(1'b0);
        tick(4);
        count_until_pll(1'b1, 60, widths[0]);
        r1 = retry_cnt;
        count_until_pll(1'b0, 60, widths[1]);
        count_until_pll(1'b1, 60, widths[2]);
        r2 = retry_cnt;
        count_until_pll(1'b0, 60, widths[3]);
        count_until_pll(1'b1, 60, widths[4]);
        total++;
        if (widths[0] !== 20 || widths[1] !== 4 || widths[2] !== 20 || widths[3] !== 4 || widths[4] !== 20)
            $display("FAIL nolock_phases: got %0d %0d %0d %0d %0d want 20 4 20 4 20",
                     widths[0], widths[1], widths[2], widths[3], widths[4]);
        else passed++;
        total++;
        if ({r1, r2, retry_cnt} !== {4'd1, 4'd2, 4'd2})
            $display("FAIL nolock_retry_steps: got %0d %0d %0d want 1 2 2", r1, r2, retry_cnt);
        else passed++;
        total++;
        if ({fail, pll_rst, sys_rst, ready} !== 4'b1110)
            $display("FAIL nolock_enter_fail: got fail=%b pll_rst=%b sys_rst=%b ready=%b want 1 1 1 0", fail, pll_rst, sys_rst, ready);
        else passed++;
        pll_locked = 1'b1;
        tick(50);
        n = 0;
        total++;
        if ({fail, pll_rst, sys_rst, ready} !== 4'b1110)
            $display("FAIL nolock_fail_sticky: got fail=%b pll_rst=%b sys_rst=%b ready=%b want 1 1 1 0", fail, pll_rst, sys_rst, ready);
        else passed++;
    endtask

    task automatic test_async_reset_fail;
        #3 rst = 1'b1;
        #1;
        total++;
        if ({pll_rst, sys_rst, ready, fail, retry_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL async_rst_in_fail: got pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d want 1 1 0 0 0",
                     pll_rst, sys_rst, ready, fail, retry_cnt);
        else passed++;
    endtask

    task automatic test_timeout_collision;
        int n;
        bit saw;
        restart(1'b0);
        tick(4);
        tick(17);
        pll_locked = 1'b1;
        tick(3);
        total++;
        if ({pll_rst, retry_cnt, fail} !== {1'b0, 4'd0, 1'b0})
            $display("FAIL collision_lock_wins: got pll_rst=%b retry=%0d fail=%b want 0 0 0", pll_rst, retry_cnt, fail);
        else passed++;
        tick_until_ready(40, n, saw);
        total++;
        if (n !== 8 || saw !== 1'b0) $display("FAIL collision_ready_edge: got ticks=%0d pll_rst_seen=%b want 8 0", n, saw);
        else passed++;
    endtask

    task automatic test_async_reset_stable;
        int n;
        bit saw;
        restart(1'b1);
        tick(9);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({pll_rst, sys_rst, ready, fail, retry_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL async_rst_in_stable: got pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d want 1 1 0 0 0",
                     pll_rst, sys_rst, ready, fail, retry_cnt);
        else passed++;
        tick(2);
        rst = 1'b0;
        tick_until_ready(40, n, saw);
        total++;
        if (n !== 13) $display("FAIL async_restart_ready: got %0d want 13", n);
        else passed++;
    endtask

    task automatic test_invariants;
        total++;
        if (lost_back_to_back !== 0 || invariant_bad !== 0)
            $display("FAIL invariants: got back_to_back=%0d ready_violations=%0d want 0 0", lost_back_to_back, invariant_bad);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_loss_run();
        test_glitch_stable();
        test_no_lock();
        test_async_reset_fail();
        test_timeout_collision();
        test_async_reset_stable();
        test_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
